regfile_wb_sequencer: RTL and testbench

Write-port sequencer feeding the single write port of the 32x64 ARM register file (X31 = XZR). Accepts writeback results from the MEM/WB stage over a valid/ready handshake, each carrying up to two destination writes (e.g. load-pair, post-index base update). Serializes them onto the register file's `WriteRegister`/`WriteData`/`RegWrite` inputs one per cycle, and stalls the upstream stage while a second write is pending.

---
 rtl/regfile_wb_sequencer.sv | 127 ++++++++++++
 tb/tb_regfile_wb_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer
// Takes MEM/WB results that carry up to two destination writes and issues
// them to the single register-file write port, one write per cycle. While a
// second (slot 1) write is held, in_ready drops for one cycle.
// Optional feature macro: WB_SEQ_FWD_EN. When it is defined, the held slot 1
// write is exposed on fwd_* so decode can bypass it before it is written.
module regfile_wb_sequencer #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_we0,
   input  logic [ADDR_W-1:0] in_rd0,
   input  logic [DATA_W-1:0] in_data0,
   input  logic              in_we1,
   input  logic [ADDR_W-1:0] in_rd1,
   input  logic [DATA_W-1:0] in_data1,
   output logic [ADDR_W-1:0] WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   output logic              RegWrite,
   output logic              busy,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_reg,
   output logic [DATA_W-1:0] fwd_data
);

   typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_e;

   localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

   state_e              state_q, state_d;
   logic                accept;
   logic [ADDR_W-1:0]   wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   hold_rd_q, hold_rd_d;
   logic [DATA_W-1:0]   hold_data_q, hold_data_d;

   assign accept = in_valid & in_ready;

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // FSM next state: only a dual write leaves IDLE; SECOND always lasts one cycle
   always_comb begin
      state_d = state_q;
      if (state_q == SECOND)
         state_d = IDLE;
      else if (accept && in_we0 && in_we1)
         state_d = SECOND;
   end

   // FSM outputs: ready depends on state alone, never on in_valid
   always_comb begin
      in_ready = (state_q == IDLE);
      busy     = (state_q == SECOND);
   end

   // Next write-port value and hold-register capture. Address/data keep their
   // last value on idle cycles; only the strobe is cleared. Writes to the zero
   // register still present address/data but never raise the strobe.
   always_comb begin
      wr_reg_d    = wr_reg_q;
      wr_data_d   = wr_data_q;
      wr_en_d     = 1'b0;
      hold_rd_d   = hold_rd_q;
      hold_data_d = hold_data_q;
      if (state_q == SECOND) begin
         wr_reg_d  = hold_rd_q;
         wr_data_d = hold_data_q;
         wr_en_d   = (hold_rd_q != ZR);
      end else if (accept) begin
         if (in_we0) begin
            wr_reg_d  = in_rd0;
            wr_data_d = in_data0;
            wr_en_d   = (in_rd0 != ZR);
            if (in_we1) begin
               hold_rd_d   = in_rd1;
               hold_data_d = in_data1;
            end
         end else if (in_we1) begin
            wr_reg_d  = in_rd1;
            wr_data_d = in_data1;
            wr_en_d   = (in_rd1 != ZR);
         end
      end
   end

   // Registered write port and hold register; reset drops any held write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_reg_q    <= '0;
         wr_data_q   <= '0;
         wr_en_q     <= 1'b0;
         hold_rd_q   <= '0;
         hold_data_q <= '0;
      end else begin
         wr_reg_q    <= wr_reg_d;
         wr_data_q   <= wr_data_d;
         wr_en_q     <= wr_en_d;
         hold_rd_q   <= hold_rd_d;
         hold_data_q <= hold_data_d;
      end
   end

   assign WriteRegister = wr_reg_q;
   assign WriteData     = wr_data_q;
   assign RegWrite      = wr_en_q;

`ifdef WB_SEQ_FWD_EN
   assign fwd_valid = busy & (hold_rd_q != ZR);
   assign fwd_reg   = hold_rd_q;
   assign fwd_data  = hold_data_q;
`else
   assign fwd_valid = 1'b0;
   assign fwd_reg   = '0;
   assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Bench for regfile_wb_sequencer: directed cases then random traffic, checked
// against a queue-of-pending-writes model and a model register file.
module tb_regfile_wb_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready;
   logic        in_we0, in_we1;
   logic [4:0]  in_rd0, in_rd1;
   logic [63:0] in_data0, in_data1;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;
   logic        RegWrite, busy, fwd_valid;
   logic [4:0]  fwd_reg;
   logic [63:0] fwd_data;

   regfile_wb_sequencer #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_we0(in_we0), .in_rd0(in_rd0), .in_data0(in_data0),
      .in_we1(in_we1), .in_rd1(in_rd1), .in_data1(in_data1),
      .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
      .busy(busy), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] d;
   } wr_t;

   wr_t         mq[$];          // writes accepted but not yet issued
   logic [63:0] mrf[32];        // model register file
   logic [63:0] trf[32];        // register file built from DUT port activity
   logic        e_iss, e_we;
   logic [4:0]  e_rd;
   logic [63:0] e_data;
   int          n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
   endtask

   // Compare all outputs to the model, then let the TB regfile capture the write
   task automatic check_outputs();
      chk("in_ready", in_ready, mq.size() == 0);
      chk("busy", busy, mq.size() != 0);
      chk("RegWrite", RegWrite, e_we);
      if (e_iss) begin
         chk("WriteRegister", WriteRegister, e_rd);
         chk("WriteData", WriteData, e_data);
      end
`ifdef WB_SEQ_FWD_EN
      chk("fwd_valid", fwd_valid, (mq.size() != 0) && (mq[0].rd != 5'd31));
      if (mq.size() != 0) begin
         chk("fwd_reg", fwd_reg, mq[0].rd);
         chk("fwd_data", fwd_data, mq[0].d);
      end
`else
      chk("fwd_valid", fwd_valid, 0);
      chk("fwd_reg", fwd_reg, 0);
      chk("fwd_data", fwd_data, 0);
`endif
      if (RegWrite) trf[WriteRegister] = WriteData;
   endtask

   // One clock: drive inputs, advance the model at the edge, check at negedge
   task automatic cyc(input logic v, input logic w0, input logic [4:0] r0, input logic [63:0] d0,
                      input logic w1, input logic [4:0] r1, input logic [63:0] d1);
      logic acc;
      wr_t  w;
      in_valid = v; in_we0 = w0; in_rd0 = r0; in_data0 = d0;
      in_we1 = w1; in_rd1 = r1; in_data1 = d1;
      acc = v && (mq.size() == 0);
      @(posedge clk);
      if (acc) begin
         if (w0) mq.push_back('{rd: r0, d: d0});
         if (w1) mq.push_back('{rd: r1, d: d1});
      end
      e_iss = 1'b0;
      e_we  = 1'b0;
      if (mq.size() != 0) begin
         w      = mq.pop_front();
         e_iss  = 1'b1;
         e_rd   = w.rd;
         e_data = w.d;
         e_we   = (w.rd != 5'd31);
         if (e_we) mrf[w.rd] = w.d;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle();
      cyc(0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
   endtask

   initial begin
      logic [4:0] r0, r1;
      for (int i = 0; i < 32; i++) begin mrf[i] = '0; trf[i] = '0; end
      e_iss = 0; e_we = 0; e_rd = 0; e_data = 0;
      reset_n = 1'b0;
      in_valid = 0; in_we0 = 0; in_we1 = 0;
      in_rd0 = 0; in_rd1 = 0; in_data0 = 0; in_data1 = 0;
      #1;
      chk("rst_RegWrite", RegWrite, 0);
      chk("rst_WriteRegister", WriteRegister, 0);
      chk("rst_WriteData", WriteData, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_fwd_valid", fwd_valid, 0);
      chk("rst_fwd_reg", fwd_reg, 0);
      chk("rst_fwd_data", fwd_data, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // single write, accepted on the first edge after reset release
      cyc(1, 1, 5'd5, 64'hDEAD_BEEF, 0, 5'd0, 64'd0);
      idle();
      // dual write
      cyc(1, 1, 5'd3, 64'h11, 1, 5'd4, 64'h22);
      cyc(1, 1, 5'd9, 64'h99, 0, 5'd0, 64'd0);   // ignored while in SECOND
      idle();
      // zero register: single, then dual with slot 1 to XZR
      cyc(1, 1, 5'd31, 64'hFF, 0, 5'd0, 64'd0);
      cyc(1, 1, 5'd6, 64'h66, 1, 5'd31, 64'h77);
      idle();
      // slot 1 only, and a discarded empty result
      cyc(1, 0, 5'd0, 64'd0, 1, 5'd12, 64'hC0FFEE);
      cyc(1, 0, 5'd13, 64'h13, 0, 5'd14, 64'h14);
      idle();
      // same destination in both slots
      cyc(1, 1, 5'd7, 64'h1, 1, 5'd7, 64'h2);
      idle();
      chk("same_dest_X7", trf[7], 64'h2);
      // back-to-back singles, then a dual, then a single
      cyc(1, 1, 5'd1, 64'hA1, 0, 5'd0, 64'd0);
      cyc(1, 1, 5'd2, 64'hA2, 0, 5'd0, 64'd0);
      cyc(1, 1, 5'd8, 64'hA3, 0, 5'd0, 64'd0);
      cyc(1, 1, 5'd10, 64'hB0, 1, 5'd11, 64'hB1);
      cyc(1, 1, 5'd15, 64'hB2, 0, 5'd0, 64'd0);
      cyc(1, 1, 5'd16, 64'hB3, 0, 5'd0, 64'd0);
      idle();

      // reset while in SECOND discards the held write
      cyc(1, 1, 5'd20, 64'hAA, 1, 5'd21, 64'hBB);
      reset_n = 1'b0;
      #1;
      chk("midrst_RegWrite", RegWrite, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_fwd_valid", fwd_valid, 0);
      mq.delete();
      e_iss = 0; e_we = 0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) idle();
      chk("midrst_X21", trf[21], 64'h0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         r0 = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 4) == 0) ? r0 : 5'($urandom_range(0, 31));
         cyc($urandom_range(0, 9) < 7, 1'($urandom), r0, {$urandom, $urandom},
             1'($urandom), r1, {$urandom, $urandom});
      end
      repeat (2) idle();
      for (int i = 0; i < 32; i++) chk($sformatf("rf_X%0d", i), trf[i], mrf[i]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
